mul_hilo_writeback: RTL and testbench

//  Downstream stage of the sequential integer multiplier. Accepts the 64-bit signed

---
 rtl/mul_pkg.sv | 18 +
 rtl/mul_prod_fifo.sv | 63 ++++++
 rtl/mul_hilo_writeback.sv | 113 +++++++++++
 tb/tb_mul_hilo_writeback.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants for the multiplier writeback slice: word/product widths and
// the helper that sizes FIFO pointers.
package mul_pkg;

   localparam int WORD_W  = 32;
   localparam int PROD_W  = 2 * WORD_W;
   localparam int ENTRY_W = PROD_W + 1;

   // A depth of one still needs a one-bit pointer so the vectors stay legal
   function automatic int ptr_w(input int depth);
      if (depth > 2) begin
         return $clog2(depth);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/mul_prod_fifo.sv
// Product FIFO: DEPTH entries of {ovf, product}. It keeps read/write pointers
// and an occupancy count, and shows the head entry combinationally.
module mul_prod_fifo
   import mul_pkg::*;
#(
   parameter int WIDTH = ENTRY_W,
   parameter int DEPTH = 2,
   localparam int PTR_W = ptr_w(DEPTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             push_s;
   logic             pop_s;

   assign full   = (count_r == (PTR_W+1)'(DEPTH));
   assign empty  = (count_r == '0);
   assign push_s = push & ~full;
   assign pop_s  = pop & ~empty;
   assign head   = mem_r[rd_ptr_r];
   assign count  = count_r;

   // Entry storage; contents are don't-care once the pointers are reset
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (PTR_W+1)'(1);
            2'b01:   count_r <= count_r - (PTR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/mul_hilo_writeback.sv
// Multiplier writeback stage: buffers products, commits them to HI/LO when the
// pipeline drains, services mthi/mtlo and tracks sticky overflow/non-fit.
module mul_hilo_writeback
   import mul_pkg::*;
#(
   parameter int WORD_W = mul_pkg::WORD_W,
   parameter int DEPTH  = 2,
   localparam int PTR_W = ptr_w(DEPTH)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2*WORD_W-1:0] in_prod,
   input  logic                in_ovf,
   input  logic                drain_en,
   input  logic                mthi_we,
   input  logic                mtlo_we,
   input  logic [WORD_W-1:0]   wdata,
   input  logic                ovf_clr,
   output logic [WORD_W-1:0]   hi,
   output logic [WORD_W-1:0]   lo,
   output logic                ovf_sticky,
   output logic [PTR_W:0]      pending
);

   localparam int E_W = 2 * WORD_W + 1;

   logic [E_W-1:0]    head_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic              push_s;
   logic              commit_s;
   logic [WORD_W:0]   upper_s;
   logic              nofit_s;
   logic              set_s;
   logic [WORD_W-1:0] hi_r;
   logic [WORD_W-1:0] lo_r;
   logic              sticky_r;
   logic [WORD_W-1:0] hi_nxt_s;
   logic [WORD_W-1:0] lo_nxt_s;
   logic              sticky_nxt_s;

   assign in_ready = ~fifo_full_s;
   assign push_s   = in_valid & in_ready;
   assign commit_s = drain_en & ~fifo_empty_s;

   mul_prod_fifo #(
      .WIDTH (E_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (commit_s),
      .wdata ({in_ovf, in_prod}),
      .head  (head_s),
      .count (pending),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // The product fits in a signed word only if bits [2W-1:W-1] are all equal
   assign upper_s = head_s[2*WORD_W-1:WORD_W-1];
   assign nofit_s = ~((&upper_s) | ~(|upper_s));
   assign set_s   = commit_s & (head_s[E_W-1] | nofit_s);

   // Next-state selection: mt writes override the popped half they target
   always_comb begin
      hi_nxt_s     = hi_r;
      lo_nxt_s     = lo_r;
      sticky_nxt_s = sticky_r;
      if (mthi_we) begin
         hi_nxt_s = wdata;
      end else if (commit_s) begin
         hi_nxt_s = head_s[2*WORD_W-1:WORD_W];
      end else begin
         hi_nxt_s = hi_r;
      end
      if (mtlo_we) begin
         lo_nxt_s = wdata;
      end else if (commit_s) begin
         lo_nxt_s = head_s[WORD_W-1:0];
      end else begin
         lo_nxt_s = lo_r;
      end
      if (set_s) begin
         sticky_nxt_s = 1'b1;
      end else if (ovf_clr) begin
         sticky_nxt_s = 1'b0;
      end else begin
         sticky_nxt_s = sticky_r;
      end
   end

   // Architectural HI/LO and sticky status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_r     <= '0;
         lo_r     <= '0;
         sticky_r <= 1'b0;
      end else begin
         hi_r     <= hi_nxt_s;
         lo_r     <= lo_nxt_s;
         sticky_r <= sticky_nxt_s;
      end
   end

   assign hi         = hi_r;
   assign lo         = lo_r;
   assign ovf_sticky = sticky_r;

endmodule

// File: tb/tb_mul_hilo_writeback.sv
// Self-checking bench for mul_hilo_writeback: directed scenarios plus a random
// run compared against a queue-based reference model.
module tb_mul_hilo_writeback;

   localparam int W = 32;
   localparam int D = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [2*W-1:0] in_prod;
   logic          in_ovf;
   logic          drain_en;
   logic          mthi_we;
   logic          mtlo_we;
   logic [W-1:0]  wdata;
   logic          ovf_clr;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;
   logic          ovf_sticky;
   logic [1:0]    pending;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] m_hi;
   logic [W-1:0] m_lo;
   logic         m_sticky;
   logic [2*W:0] q[$];

   mul_hilo_writeback #(.WORD_W(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_prod(in_prod), .in_ovf(in_ovf), .drain_en(drain_en),
      .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata), .ovf_clr(ovf_clr),
      .hi(hi), .lo(lo), .ovf_sticky(ovf_sticky), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic idle();
      in_valid = 1'b0; in_prod = '0; in_ovf = 1'b0; drain_en = 1'b0;
      mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0; ovf_clr = 1'b0;
   endtask

   task automatic model_reset();
      m_hi = '0; m_lo = '0; m_sticky = 1'b0; q.delete();
   endtask

   // Reference: what one clock edge does to the architectural state
   task automatic model_edge();
      logic [2*W:0]        e;
      logic signed [2*W-1:0] p;
      logic                set;
      int                  sz;
      sz  = q.size();
      set = 1'b0;
      if (drain_en && sz != 0) begin
         e   = q.pop_front();
         p   = e[2*W-1:0];
         set = e[2*W] || (p > 64'sd2147483647) || (p < -64'sd2147483648);
         if (!mthi_we) m_hi = e[2*W-1:W];
         if (!mtlo_we) m_lo = e[W-1:0];
      end
      if (mthi_we) m_hi = wdata;
      if (mtlo_we) m_lo = wdata;
      if (set) m_sticky = 1'b1;
      else if (ovf_clr) m_sticky = 1'b0;
      if (in_valid && sz != D) q.push_back({in_ovf, in_prod});
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h exp %h", hi, 32'h0); end
      n_tests++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h exp %h", lo, 32'h0); end
      n_tests++; if (pending !== 2'd0) begin n_fail++; $display("FAIL reset_pending got %0d exp 0", pending); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      n_tests++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got %b exp 0", ovf_sticky); end
   endtask

   task automatic test_single();
      idle();
      in_valid = 1'b1; in_prod = 64'h0000_0000_0000_0006; drain_en = 1'b1;
      tick();
      in_valid = 1'b0;
      n_tests++; if (lo !== 32'h0) begin n_fail++; $display("FAIL single_nobypass_lo got %h exp %h", lo, 32'h0); end
      n_tests++; if (pending !== 2'd1) begin n_fail++; $display("FAIL single_pending got %0d exp 1", pending); end
      tick();
      n_tests++; if (hi !== 32'h0 || lo !== 32'h6) begin n_fail++; $display("FAIL single_hilo got %h_%h exp 0_6", hi, lo); end
      n_tests++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL single_sticky got %b exp 0", ovf_sticky); end
      n_tests++; if (pending !== 2'd0) begin n_fail++; $display("FAIL single_empty got %0d exp 0", pending); end
   endtask

   task automatic test_order_full();
      idle();
      in_valid = 1'b1; in_prod = 64'hFFFF_FFFF_FFFF_FFFA;
      tick();
      in_prod = 64'h1;
      tick();
      n_tests++; if (pending !== 2'd2) begin n_fail++; $display("FAIL full_pending got %0d exp 2", pending); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
      in_prod = 64'h7;
      tick();
      n_tests++; if (pending !== 2'd2 || lo !== 32'h6) begin n_fail++; $display("FAIL full_hold got %0d/%h exp 2/00000006", pending, lo); end
      drain_en = 1'b1;
      tick();
      n_tests++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL order_a got %h_%h exp ffffffff_fffffffa", hi, lo); end
      n_tests++; if (pending !== 2'd1) begin n_fail++; $display("FAIL order_a_pending got %0d exp 1", pending); end
      tick();
      in_valid = 1'b0;
      n_tests++; if (hi !== 32'h0 || lo !== 32'h1 || pending !== 2'd1) begin n_fail++; $display("FAIL order_b got %h_%h/%0d exp 0_1/1", hi, lo, pending); end
      tick();
      n_tests++; if (lo !== 32'h7 || pending !== 2'd0) begin n_fail++; $display("FAIL order_c got %h/%0d exp 7/0", lo, pending); end
      n_tests++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL order_sticky got %b exp 0", ovf_sticky); end
   endtask

   task automatic test_nofit_sticky();
      idle();
      in_valid = 1'b1; in_prod = 64'h0000_0001_0000_0000; drain_en = 1'b1;
      tick();
      in_valid = 1'b0; ovf_clr = 1'b1;
      tick();
      n_tests++; if (hi !== 32'h1 || lo !== 32'h0) begin n_fail++; $display("FAIL nofit_hilo got %h_%h exp 1_0", hi, lo); end
      n_tests++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL nofit_set_wins got %b exp 1", ovf_sticky); end
      tick();
      n_tests++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL nofit_clr got %b exp 0", ovf_sticky); end
      ovf_clr = 1'b0; in_valid = 1'b1; in_prod = 64'h3; in_ovf = 1'b1;
      tick();
      in_valid = 1'b0; in_ovf = 1'b0;
      tick();
      n_tests++; if (ovf_sticky !== 1'b1 || lo !== 32'h3) begin n_fail++; $display("FAIL ovf_flag got %b/%h exp 1/3", ovf_sticky, lo); end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      n_tests++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_flag_clr got %b exp 0", ovf_sticky); end
   endtask

   task automatic test_mt_priority();
      idle();
      in_valid = 1'b1; in_prod = 64'h0000_0000_1234_5678; drain_en = 1'b1;
      tick();
      in_valid = 1'b0; mthi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      tick();
      n_tests++; if (hi !== 32'hDEAD_BEEF || lo !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_prio got %h_%h exp deadbeef_12345678", hi, lo); end
      mthi_we = 1'b0; mtlo_we = 1'b1; wdata = 32'hCAFE_F00D;
      tick();
      mtlo_we = 1'b0;
      n_tests++; if (hi !== 32'hDEAD_BEEF || lo !== 32'hCAFE_F00D || pending !== 2'd0) begin n_fail++; $display("FAIL mtlo got %h_%h/%0d exp deadbeef_cafef00d/0", hi, lo, pending); end
   endtask

   task automatic test_back_to_back();
      idle();
      in_valid = 1'b1; in_prod = 64'h11;
      tick();
      in_prod = 64'h22;
      tick();
      drain_en = 1'b1; in_prod = 64'h33;
      tick();
      n_tests++; if (pending !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_nopush got %0d/%b exp 1/1", pending, in_ready); end
      n_tests++; if (lo !== 32'h11) begin n_fail++; $display("FAIL full_pop_lo got %h exp 11", lo); end
      in_valid = 1'b0;
      tick();
      tick();
      n_tests++; if (lo !== 32'h22 || pending !== 2'd0) begin n_fail++; $display("FAIL drain_empty got %h/%0d exp 22/0", lo, pending); end
   endtask

   task automatic test_reset_midstream();
      idle();
      in_valid = 1'b1; in_prod = 64'h0000_0005_0000_0000; drain_en = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      drain_en = 1'b0; in_valid = 1'b1; in_prod = 64'h44;
      tick();
      tick();
      in_valid = 1'b0;
      n_tests++; if (pending !== 2'd2 || ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL pre_reset got %0d/%b exp 2/1", pending, ovf_sticky); end
      rst = 1'b1;
      #2;
      n_tests++; if (in_ready !== 1'b1 || pending !== 2'd0 || hi !== 32'h0) begin n_fail++; $display("FAIL async_reset got %b/%0d/%h exp 1/0/0", in_ready, pending, hi); end
      rst = 1'b0;
      model_reset();
      #1;
      tick();
      test_reset();
   endtask

   task automatic test_random();
      idle();
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         drain_en = ($urandom_range(0, 2) != 0);
         in_ovf   = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 3))
            0: in_prod = {$urandom(), $urandom()};
            1: in_prod = {32'h0, 1'b0, 31'($urandom())};
            2: in_prod = {32'hFFFF_FFFF, 1'b1, 31'($urandom())};
            default: in_prod = {31'h0, 1'b1, $urandom()};
         endcase
         mthi_we = ($urandom_range(0, 7) == 0);
         mtlo_we = ($urandom_range(0, 7) == 0);
         wdata   = $urandom();
         ovf_clr = ($urandom_range(0, 5) == 0);
         tick();
         n_tests++; if (hi !== m_hi) begin n_fail++; $display("FAIL rand_hi cyc %0d got %h exp %h", i, hi, m_hi); end
         n_tests++; if (lo !== m_lo) begin n_fail++; $display("FAIL rand_lo cyc %0d got %h exp %h", i, lo, m_lo); end
         n_tests++; if (ovf_sticky !== m_sticky) begin n_fail++; $display("FAIL rand_sticky cyc %0d got %b exp %b", i, ovf_sticky, m_sticky); end
         n_tests++; if (pending !== 2'(q.size())) begin n_fail++; $display("FAIL rand_pending cyc %0d got %0d exp %0d", i, pending, q.size()); end
         n_tests++; if (in_ready !== (q.size() != D)) begin n_fail++; $display("FAIL rand_in_ready cyc %0d got %b exp %b", i, in_ready, q.size() != D); end
      end
      idle();
   endtask

   initial begin
      idle();
      model_reset();
      rst = 1'b1;
      #12;
      rst = 1'b0;
      test_reset();
      test_single();
      test_order_full();
      test_nofit_sticky();
      test_mt_priority();
      test_back_to_back();
      test_reset_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
